// File: rtl/stereo_sample_packer_if.sv
// stereo_sample_packer_if: bundle of the stereo packer's upstream subframe inputs and downstream FIFO handshake
//   master: drives din/vin, dauxin/vauxin, channel, kill, ovf_clr, out_ready; observes the FIFO head and status
//   slave : the packer itself; consumes subframe strobes, presents out_left/out_right/out_valid/level/pair_err/overflow
interface stereo_sample_packer_if #(
    parameter int DEPTH = 16,
    parameter int LW = $clog2(DEPTH) + 1
);
    logic [19:0] din;
    logic vin;
    logic [3:0] dauxin;
    logic vauxin;
    logic channel;
    logic kill;
    logic ovf_clr;
    logic out_ready;
    logic [23:0] out_left;
    logic [23:0] out_right;
    logic out_valid;
    logic [LW-1:0] level;
    logic pair_err;
    logic overflow;
    modport master (
        output din, vin, dauxin, vauxin, channel, kill, ovf_clr, out_ready,
        input out_left, out_right, out_valid, level, pair_err, overflow
    );
    modport slave (
        input din, vin, dauxin, vauxin, channel, kill, ovf_clr, out_ready,
        output out_left, out_right, out_valid, level, pair_err, overflow
    );
endinterface

// File: rtl/stereo_sample_packer.sv
// stereo_sample_packer: pairs channel-A/B subframes into stereo words and queues them in a DEPTH-entry FIFO
//   clk : receive-domain clock
//   rst : asynchronous active-low reset
//   bus : stereo_sample_packer_if.slave (subframe inputs, kill, ovf_clr, out_ready in; FIFO head, level, pair_err, overflow out)
//   PACKER_AUX_EN defined: aux nibble latched into the low 4 bits of each word; undefined: low nibble is zero
module stereo_sample_packer #(
    parameter int DEPTH = 16,
    parameter int LW = $clog2(DEPTH) + 1
) (
    input logic clk,
    input logic rst,
    stereo_sample_packer_if.slave bus
);
    typedef enum logic {WAIT_A, WAIT_B} state_t;
    state_t state;
    logic [23:0] left_q;
    logic [47:0] mem [DEPTH];
    logic [LW-1:0] wr_ptr, rd_ptr, level_q;
    logic pair_err_q, overflow_q;
    logic [23:0] word;
    logic vin_ok, push, full, empty, pop, wr_en, drop;
`ifdef PACKER_AUX_EN
    logic [3:0] aux_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) aux_q <= '0;
        else if (bus.kill || bus.vin) aux_q <= '0;
        else if (bus.vauxin) aux_q <= bus.dauxin;
    assign word = {bus.din, aux_q};
`else
    logic unused_aux;
    assign unused_aux = ^{bus.dauxin, bus.vauxin};
    assign word = {bus.din, 4'h0};
`endif
    assign vin_ok = bus.vin && !bus.kill;
    assign push = vin_ok && state == WAIT_B && bus.channel;
    assign empty = wr_ptr == rd_ptr;
    // pointers carry one extra wrap bit: equal low bits with differing MSB means full
    assign full = (wr_ptr ^ rd_ptr) == {1'b1, {(LW-1){1'b0}}};
    assign pop = !empty && bus.out_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the pair
    assign wr_en = push && (!full || pop);
    assign drop = push && full && !pop;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_A;
            left_q <= '0;
            pair_err_q <= 1'b0;
        end else begin
            pair_err_q <= vin_ok && (state == WAIT_A ? bus.channel : !bus.channel);
            if (bus.kill) begin
                state <= WAIT_A;
                left_q <= '0;
            end else if (bus.vin) begin
                if (!bus.channel) begin
                    left_q <= word;
                    state <= WAIT_B;
                end else begin
                    state <= WAIT_A;
                end
            end
        end
    end
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr[LW-2:0]] <= {left_q, word};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level_q <= level_q + LW'(wr_en) - LW'(pop);
            overflow_q <= drop || (overflow_q && !bus.ovf_clr);
        end
    end
    assign bus.out_valid = !empty;
    assign bus.out_left = empty ? 24'h0 : mem[rd_ptr[LW-2:0]][47:24];
    assign bus.out_right = empty ? 24'h0 : mem[rd_ptr[LW-2:0]][23:0];
    assign bus.level = level_q;
    assign bus.pair_err = pair_err_q;
    assign bus.overflow = overflow_q;
endmodule
